// File: rtl/regfile_wb_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_scheduler_if : write-back request, issue and write-port bus   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface regfile_wb_scheduler_if #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 3,
    parameter int NUM_REGS = 8
);
    logic                imm_req, alu_req, mem_req;
    logic [REG_AW-1:0]   imm_addr, alu_addr, mem_addr;
    logic [DATA_W-1:0]   imm_data, alu_data, mem_data;
    logic                imm_gnt, alu_gnt, mem_gnt;
    logic                issue_valid, issue_writes;
    logic [REG_AW-1:0]   issue_dst, issue_src_a, issue_src_b;
    logic                stall;
    logic                wr_en;
    logic [REG_AW-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] pending;

    modport master (
        output imm_req, alu_req, mem_req, imm_addr, alu_addr, mem_addr,
               imm_data, alu_data, mem_data,
               issue_valid, issue_writes, issue_dst, issue_src_a, issue_src_b,
        input  imm_gnt, alu_gnt, mem_gnt, stall, wr_en, wr_addr, wr_data, pending
    );

    modport slave (
        input  imm_req, alu_req, mem_req, imm_addr, alu_addr, mem_addr,
               imm_data, alu_data, mem_data,
               issue_valid, issue_writes, issue_dst, issue_src_a, issue_src_b,
        output imm_gnt, alu_gnt, mem_gnt, stall, wr_en, wr_addr, wr_data, pending
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_scheduler : round-robin write-port arbiter + RAW/WAW scoreboard|
// | Option: WB_BYPASS_EN masks the bit cleared by a same-cycle grant.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_wb_scheduler #(
    parameter int DATA_W   = 8,
    parameter int REG_AW   = 3,
    parameter int NUM_REGS = 8
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    regfile_wb_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        SRC_IMM = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MEM = 2'd2
    } src_e;

    src_e                rr_last_q, rr_last_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                wr_en_q;
    logic [REG_AW-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;

    logic [2:0]          w_req;
    logic [2:0]          w_gnt;
    logic                w_gnt_any;
    src_e                w_src;
    logic [REG_AW-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_data;
    logic [NUM_REGS-1:0] w_clr_mask, w_set_mask, w_lookup;
    logic                w_stall, w_accept;

    assign w_req = {bus.mem_req, bus.alu_req, bus.imm_req};

    // Search starts at the source after the last winner and wraps.
    always_comb begin
        w_src = rr_last_q;
        case (rr_last_q)
            SRC_IMM: begin
                if      (w_req[1]) w_src = SRC_ALU;
                else if (w_req[2]) w_src = SRC_MEM;
                else if (w_req[0]) w_src = SRC_IMM;
            end
            SRC_ALU: begin
                if      (w_req[2]) w_src = SRC_MEM;
                else if (w_req[0]) w_src = SRC_IMM;
                else if (w_req[1]) w_src = SRC_ALU;
            end
            default: begin
                if      (w_req[0]) w_src = SRC_IMM;
                else if (w_req[1]) w_src = SRC_ALU;
                else if (w_req[2]) w_src = SRC_MEM;
            end
        endcase
        w_gnt_any = reset_n & (|w_req);
        w_gnt     = w_gnt_any ? (3'b001 << w_src) : 3'b000;
        rr_last_d = w_gnt_any ? w_src : rr_last_q;
    end

    always_comb begin
        case (w_src)
            SRC_IMM: begin w_gnt_addr = bus.imm_addr; w_gnt_data = bus.imm_data; end
            SRC_ALU: begin w_gnt_addr = bus.alu_addr; w_gnt_data = bus.alu_data; end
            default: begin w_gnt_addr = bus.mem_addr; w_gnt_data = bus.mem_data; end
        endcase
    end

    assign w_clr_mask = w_gnt_any ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << w_gnt_addr)
                                  : '0;

`ifdef WB_BYPASS_EN
    assign w_lookup = pending_q & ~w_clr_mask;
`else
    assign w_lookup = pending_q;
`endif

    assign w_stall  = ~reset_n |
                      (bus.issue_valid & (w_lookup[bus.issue_src_a] |
                                          w_lookup[bus.issue_src_b] |
                                          (bus.issue_writes & w_lookup[bus.issue_dst])));
    assign w_accept = bus.issue_valid & ~w_stall;

    assign w_set_mask = (w_accept & bus.issue_writes)
                      ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << bus.issue_dst) : '0;

    // Set is applied after clear so a same-address issue wins.
    assign pending_d = (pending_q & ~w_clr_mask) | w_set_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_last_q <= SRC_MEM;
            pending_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            pending_q <= pending_d;
            wr_en_q   <= w_gnt_any;
            if (w_gnt_any) begin
                wr_addr_q <= w_gnt_addr;
                wr_data_q <= w_gnt_data;
            end
        end
    end

    assign bus.imm_gnt = w_gnt[0];
    assign bus.alu_gnt = w_gnt[1];
    assign bus.mem_gnt = w_gnt[2];
    assign bus.stall   = w_stall;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_scheduler : directed + random bench with reference model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_scheduler;
    localparam int DATA_W   = 8;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) bus ();

    regfile_wb_scheduler #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    // Stimulus: index 0=IMM, 1=ALU, 2=MEM
    logic              req  [3];
    logic [REG_AW-1:0] addr [3];
    logic [DATA_W-1:0] data [3];
    logic              iv, iw;
    logic [REG_AW-1:0] idst, ia, ib;

    // Reference model state
    logic [NUM_REGS-1:0] m_pend;
    int                  m_last;
    logic                m_wr_en;
    logic [REG_AW-1:0]   m_wr_addr;
    logic [DATA_W-1:0]   m_wr_data;

    int         exp_src;
    logic [2:0] exp_gnt, obs_gnt;
    logic       exp_stall, obs_stall;

    int n_vec = 0;
    int n_err = 0;

    task automatic clear_inputs();
        for (int s = 0; s < 3; s++) begin req[s] = 1'b0; addr[s] = '0; data[s] = '0; end
        iv = 1'b0; iw = 1'b0; idst = '0; ia = '0; ib = '0;
    endtask

    // One clock: drive, sample combinational outputs mid-cycle, advance model at the edge.
    task automatic tick();
        logic [NUM_REGS-1:0] look;
        int s;
        bus.imm_req = req[0];  bus.alu_req = req[1];  bus.mem_req = req[2];
        bus.imm_addr = addr[0]; bus.alu_addr = addr[1]; bus.mem_addr = addr[2];
        bus.imm_data = data[0]; bus.alu_data = data[1]; bus.mem_data = data[2];
        bus.issue_valid = iv; bus.issue_writes = iw;
        bus.issue_dst = idst; bus.issue_src_a = ia; bus.issue_src_b = ib;
        @(negedge clk);
        exp_src = -1;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                s = (m_last + 1 + k) % 3;
                if (exp_src < 0 && req[s]) exp_src = s;
            end
        end
        exp_gnt = (exp_src < 0) ? 3'b000 : 3'(1 << exp_src);
        look = m_pend;
`ifdef WB_BYPASS_EN
        if (exp_src >= 0) look[addr[exp_src]] = 1'b0;
`endif
        exp_stall = !rst_n || (iv && (look[ia] || look[ib] || (iw && look[idst])));
        obs_gnt   = {bus.mem_gnt, bus.alu_gnt, bus.imm_gnt};
        obs_stall = bus.stall;
        @(posedge clk);
        if (!rst_n) begin
            m_pend = '0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_last = 2;
        end else begin
            m_wr_en = (exp_src >= 0);
            if (exp_src >= 0) begin
                m_wr_addr = addr[exp_src];
                m_wr_data = data[exp_src];
                m_pend[addr[exp_src]] = 1'b0;
                m_last = exp_src;
            end
            if (iv && iw && !exp_stall) m_pend[idst] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        req[0] = 1'b1; addr[0] = 3'd2; iv = 1'b1;
        rst_n = 1'b0;
        tick();
        n_vec++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b expected 1", obs_stall); end
        n_vec++; if (obs_gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b expected 000", obs_gnt); end
        n_vec++; if (bus.pending !== 8'h00) begin n_err++; $display("FAIL reset_pending: got %h expected 00", bus.pending); end
        n_vec++; if (bus.wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
        clear_inputs();
        rst_n = 1'b1;
        tick();
        n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b expected 0", obs_stall); end
        n_vec++; if (bus.pending !== 8'h00) begin n_err++; $display("FAIL idle_pending: got %h expected 00", bus.pending); end
        n_vec++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 3'd0 || bus.wr_data !== 8'h00) begin
            n_err++; $display("FAIL idle_wr: got en=%b a=%0d d=%h expected en=0 a=0 d=00", bus.wr_en, bus.wr_addr, bus.wr_data); end
    endtask

    task automatic test_round_robin();
        logic [2:0] g_seq [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
        logic       e_seq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0] a_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        logic [7:0] d_seq [5] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33};
        clear_inputs();
        for (int s = 0; s < 3; s++) begin
            req[s] = 1'b1; addr[s] = 3'(s + 1); data[s] = 8'(8'h11 * (s + 1));
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if (obs_gnt !== g_seq[c]) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", c, obs_gnt, g_seq[c]); end
            n_vec++; if (bus.wr_en !== e_seq[c] || bus.wr_addr !== a_seq[c] || bus.wr_data !== d_seq[c]) begin
                n_err++; $display("FAIL rr_wr[%0d]: got en=%b a=%0d d=%h expected en=%b a=%0d d=%h",
                                  c, bus.wr_en, bus.wr_addr, bus.wr_data, e_seq[c], a_seq[c], d_seq[c]); end
            for (int s = 0; s < 3; s++) if (obs_gnt[s]) req[s] = 1'b0;
        end
    endtask

    task automatic test_raw_stall();
        clear_inputs();
        iv = 1'b1; iw = 1'b1; idst = 3'd4; ia = 3'd0; ib = 3'd0;
        tick();
        n_vec++; if (obs_stall !== 1'b0 || bus.pending[4] !== 1'b1) begin
            n_err++; $display("FAIL raw_set: got stall=%b p4=%b expected stall=0 p4=1", obs_stall, bus.pending[4]); end
        iw = 1'b0; idst = 3'd0; ia = 3'd4;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL raw_wait[%0d]: got %b expected 1", c, obs_stall); end
        end
        req[1] = 1'b1; addr[1] = 3'd4; data[1] = 8'h44;
        tick();
        req[1] = 1'b0;
        n_vec++; if (obs_gnt !== 3'b010) begin n_err++; $display("FAIL raw_gnt: got %b expected 010", obs_gnt); end
        n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 3'd4 || bus.wr_data !== 8'h44) begin
            n_err++; $display("FAIL raw_wr: got en=%b a=%0d d=%h expected en=1 a=4 d=44", bus.wr_en, bus.wr_addr, bus.wr_data); end
`ifdef WB_BYPASS_EN
        n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL raw_grant_cycle: got %b expected 0", obs_stall); end
        iv = 1'b0;
`else
        n_vec++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL raw_grant_cycle: got %b expected 1", obs_stall); end
        tick();
        n_vec++; if (obs_stall !== 1'b0) begin n_err++; $display("FAIL raw_release: got %b expected 0", obs_stall); end
        iv = 1'b0;
`endif
        n_vec++; if (bus.pending[4] !== 1'b0) begin n_err++; $display("FAIL raw_clear: got %b expected 0", bus.pending[4]); end
    endtask

    task automatic test_waw();
        clear_inputs();
        iv = 1'b1; iw = 1'b1; idst = 3'd5;
        tick();
        n_vec++; if (bus.pending[5] !== 1'b1) begin n_err++; $display("FAIL waw_set: got %b expected 1", bus.pending[5]); end
        tick();
        n_vec++; if (obs_stall !== 1'b1) begin n_err++; $display("FAIL waw_stall: got %b expected 1", obs_stall); end
        req[2] = 1'b1; addr[2] = 3'd5; data[2] = 8'h55;
        tick();
        req[2] = 1'b0;
        n_vec++; if (obs_gnt !== 3'b100) begin n_err++; $display("FAIL waw_gnt: got %b expected 100", obs_gnt); end
`ifndef WB_BYPASS_EN
        n_vec++; if (obs_stall !== 1'b1 || bus.pending[5] !== 1'b0) begin
            n_err++; $display("FAIL waw_grant_cycle: got stall=%b p5=%b expected stall=1 p5=0", obs_stall, bus.pending[5]); end
        tick();
`endif
        n_vec++; if (obs_stall !== 1'b0 || bus.pending[5] !== 1'b1) begin
            n_err++; $display("FAIL waw_reissue: got stall=%b p5=%b expected stall=0 p5=1", obs_stall, bus.pending[5]); end
        iv = 1'b0;
    endtask

    task automatic test_collision();
        clear_inputs();
        iv = 1'b1; iw = 1'b1; idst = 3'd6;
        tick();
        req[0] = 1'b1; addr[0] = 3'd6; data[0] = 8'h66;
        tick();
        req[0] = 1'b0; iv = 1'b0;
        n_vec++; if (obs_gnt !== 3'b001) begin n_err++; $display("FAIL coll_gnt: got %b expected 001", obs_gnt); end
`ifdef WB_BYPASS_EN
        n_vec++; if (obs_stall !== 1'b0 || bus.pending[6] !== 1'b1) begin
            n_err++; $display("FAIL coll_set_wins: got stall=%b p6=%b expected stall=0 p6=1", obs_stall, bus.pending[6]); end
`else
        n_vec++; if (obs_stall !== 1'b1 || bus.pending[6] !== 1'b0) begin
            n_err++; $display("FAIL coll_no_bypass: got stall=%b p6=%b expected stall=1 p6=0", obs_stall, bus.pending[6]); end
`endif
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        iv = 1'b1; iw = 1'b1; ia = 3'd7; ib = 3'd7;
        for (int r = 0; r < 4; r++) begin idst = 3'(r); tick(); end
        clear_inputs();
        n_vec++; if (bus.pending !== 8'h0F) begin n_err++; $display("FAIL mid_preload: got %h expected 0f", bus.pending); end
        req[1] = 1'b1; addr[1] = 3'd7; data[1] = 8'h77;
        rst_n = 1'b0;
        tick();
        n_vec++; if (obs_gnt !== 3'b000 || obs_stall !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_out: got gnt=%b stall=%b expected gnt=000 stall=1", obs_gnt, obs_stall); end
        n_vec++; if (bus.pending !== 8'h00 || bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_state: got p=%h en=%b expected p=00 en=0", bus.pending, bus.wr_en); end
        rst_n = 1'b1;
        req[0] = 1'b1; addr[0] = 3'd1; data[0] = 8'hA1;
        tick();
        req[0] = 1'b0;
        n_vec++; if (obs_gnt !== 3'b001) begin n_err++; $display("FAIL mid_first_gnt: got %b expected 001", obs_gnt); end
        tick();
        req[1] = 1'b0;
        n_vec++; if (obs_gnt !== 3'b010) begin n_err++; $display("FAIL mid_second_gnt: got %b expected 010", obs_gnt); end
    endtask

    task automatic test_random();
        clear_inputs();
        for (int c = 0; c < 500; c++) begin
            for (int s = 0; s < 3; s++) begin
                if (!req[s] || exp_src == s) begin
                    req[s]  = ($urandom_range(0, 2) != 0);
                    addr[s] = 3'($urandom);
                    data[s] = 8'($urandom);
                end
            end
            iv = ($urandom_range(0, 3) != 0);
            iw = $urandom_range(0, 1) == 1;
            idst = 3'($urandom); ia = 3'($urandom); ib = 3'($urandom);
            tick();
            n_vec++; if (obs_gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, obs_gnt, exp_gnt); end
            n_vec++; if (obs_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b expected %b", c, obs_stall, exp_stall); end
            n_vec++; if (bus.wr_en !== m_wr_en || bus.wr_addr !== m_wr_addr || bus.wr_data !== m_wr_data) begin
                n_err++; $display("FAIL rnd_wr[%0d]: got en=%b a=%0d d=%h expected en=%b a=%0d d=%h",
                                  c, bus.wr_en, bus.wr_addr, bus.wr_data, m_wr_en, m_wr_addr, m_wr_data); end
            n_vec++; if (bus.pending !== m_pend) begin n_err++; $display("FAIL rnd_pending[%0d]: got %h expected %h", c, bus.pending, m_pend); end
        end
        exp_src = -1;
    endtask

    initial begin
        m_pend = '0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_last = 2;
        exp_src = -1;
        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_raw_stall();
        test_waw();
        test_collision();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and hazard controller for the 8-bit nRisc pipeline register file. It shares the single register-file write port between three requesters: immediate load, ALU result and memory load. Requesters are granted in round-robin order. A per-register pending scoreboard stalls the decode/issue stage on RAW and WAW hazards. It sits between the execute/memory stages and the register memory, and drives its write port.

## Interface
Parameters:
- DATA_W, 8, register data width
- REG_AW, 3, register address width
- NUM_REGS, 8, number of registers (2**REG_AW)

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- imm_req / alu_req / mem_req  in  1 each  write-back request; held until granted
- imm_addr / alu_addr / mem_addr  in  REG_AW each  destination register
- imm_data / alu_data / mem_data  in  DATA_W each  write data
- imm_gnt / alu_gnt / mem_gnt  out  1 each  combinational grant; at most one high
- issue_valid  in  1  decode presents an instruction
- issue_writes  in  1  instruction will produce a write-back
- issue_dst, issue_src_a, issue_src_b  in  REG_AW each  destination and source registers
- stall  out  1  issue not accepted this cycle
- wr_en  out  1  register file write enable (registered)
- wr_addr  out  REG_AW  register file write address (registered)
- wr_data  out  DATA_W  register file write data (registered)
- pending  out  NUM_REGS  scoreboard, bit i = register i awaiting write-back

## Operation
- Arbitration: a 2-bit rr_last holds the last granted source (0=IMM, 1=ALU, 2=MEM).
  - Priority order starts at the source after rr_last and wraps: after MEM the order is IMM, ALU, MEM.
  - The highest-priority requesting source gets gnt. rr_last updates only on a grant.
- Write: on a grant edge, wr_en<=1 and wr_addr/wr_data<=the granted source's addr/data. With no grant, wr_en<=0 and wr_addr/wr_data hold.
- Scoreboard:
  - issue_accept = issue_valid & ~stall.
  - On an edge with issue_accept & issue_writes, pending[issue_dst]<=1.
  - On a grant edge, pending[granted addr]<=0.
  - Same edge, same address, set and clear both apply: set wins.
- Stall = issue_valid & (pending[src_a] | pending[src_b] | (issue_writes & pending[issue_dst])). All lookups use the registered pending.
- A grant to an address whose pending bit is clear is legal (e.g. a store-free path); the write is performed and pending is unchanged.
- Requesters are independent. Two requesters targeting the same address are served in rr order, one per cycle.
- Reset (any time, mid-operation included):
  - pending=0, wr_en=0, wr_addr=0, wr_data=0, rr_last=2.
  - While reset_n is low, all gnt=0 and stall=1.
  - In-flight requests are dropped; a requester still holding req after release is arbitrated normally.

## Timing
- Grant: same cycle as req (combinational from req and rr_last).
- Write-port latency: wr_* valid the cycle after the grant cycle, for exactly one cycle per grant. Back-to-back grants give back-to-back wr_en.
- The register file captures wr_* before the next posedge; data is readable by an instruction issued the cycle after wr_en.
- Stall release: without bypass, a dependent issue stalls through the grant cycle and is accepted the cycle after.
- Max throughput: one write per cycle. A continuously requesting source waits at most 2 cycles for a grant.

## Configuration
- WB_BYPASS_EN:
  - Defined: the stall computation masks out the bit being cleared by a grant in the same cycle, so a dependent issue is accepted in the grant cycle. That is one cycle earlier, and coincides with wr_en rising on the next edge. A same-address set from that accepted issue wins over the clear.
  - Undefined: stall uses registered pending only.

## Test plan
- Reset/idle: hold reset_n=0, then release with no requests. Required: pending=8'h00, wr_en=0, stall=0 with issue_valid=0, and stall=1 during reset.
- Round robin: imm, alu and mem requests all held high with addrs 1/2/3 and data 8'h11/22/33. Required: grants in order IMM, ALU, MEM over 3 cycles; wr_addr 1,2,3 with data 11,22,33 on the following cycles; then wr_en=0.
- RAW stall:
  - Issue with dst=4, writes=1 is accepted; next, issue with src_a=4. Required: stall=1 until alu_req addr=4 is granted.
  - Without WB_BYPASS_EN: stall=0 the cycle after the grant.
  - With WB_BYPASS_EN: stall=0 in the grant cycle.
- WAW: pending[5]=1, then issue with dst=5, writes=1. Required: stall=1. Once mem_req addr=5 is granted and stall releases, pending[5]=1 again.
- Set/clear collision (WB_BYPASS_EN): grant to addr 6 and accepted issue with dst=6 on the same edge. Required: pending[6]=1 after the edge.
- Reset mid-operation: pending=8'h0F and alu_req high, then assert reset_n=0 for one cycle. Required: pending=0, wr_en=0, alu_gnt=0 during reset, and the first grant after release goes to IMM (if requesting), else ALU.
